// File: rtl/exu_mul_pipe_ctl.sv
// Flushable, freezable integer multiply pipeline for the EXU (MUL/MULH/MULHSU/MULHU).
// Latency STAGES (2..4), one op per clock, tag carried alongside, result zeroed when idle.
module exu_mul_pipe_ctl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             rs1_sign,
  input  logic             rs2_sign,
  input  logic             low,
  input  logic             rs1_byp,
  input  logic             rs2_byp,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [XLEN-1:0]  lsu_result_dc3,
  output logic [XLEN-1:0]  out,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned OW = XLEN + 1;

  // E1 stage registers
  logic [XLEN-1:0]  a1_q, a1_d, b1_q, b1_d;
  logic             s1_q, s1_d, s2_q, s2_d, low1_q, low1_d;
  logic             byp1_q, byp1_d, byp2_q, byp2_d, v1_q, v1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // E2 stage registers
  logic signed [OW-1:0] a2_q, a2_d, b2_q, b2_d;
  logic                 low2_q, low2_d, v2_q, v2_d;
  logic [TAG_W-1:0]     tag2_q, tag2_d;

  logic [XLEN-1:0]       a_e1_c, b_e1_c;
  logic signed [PW-1:0]  prod_e2_c;
  logic [PW-1:0]         prod_last;
  logic                  low_last, v_last, busy_tail;
  logic [TAG_W-1:0]      tag_last;

  always_comb begin
    a1_d   = a1_q;
    b1_d   = b1_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    low1_d = low1_q;
    byp1_d = byp1_q;
    byp2_d = byp2_q;
    tag1_d = tag1_q;
    if (!freeze && valid_in) begin
      a1_d   = a;
      b1_d   = b;
      s1_d   = rs1_sign;
      s2_d   = rs2_sign;
      low1_d = low;
      byp1_d = rs1_byp;
      byp2_d = rs2_byp;
      tag1_d = tag_in;
    end
    v1_d = flush ? 1'b0 : (freeze ? v1_q : valid_in);
  end

  // Bypass mux stays live so the load result is taken at the E1->E2 advance
  always_comb begin
    a_e1_c = byp1_q ? lsu_result_dc3 : a1_q;
    b_e1_c = byp2_q ? lsu_result_dc3 : b1_q;
  end

  always_comb begin
    a2_d   = a2_q;
    b2_d   = b2_q;
    low2_d = low2_q;
    tag2_d = tag2_q;
    if (!freeze && v1_q) begin
      a2_d   = {s1_q & a_e1_c[XLEN-1], a_e1_c};
      b2_d   = {s2_q & b_e1_c[XLEN-1], b_e1_c};
      low2_d = low1_q;
      tag2_d = tag1_q;
    end
    v2_d = flush ? 1'b0 : (freeze ? v2_q : v1_q);
  end

  // Both operands sign-extended to the kept width; the low PW bits equal the full product's
  always_comb begin
    prod_e2_c = PW'(a2_q) * PW'(b2_q);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      a1_q   <= '0;
      b1_q   <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      low1_q <= 1'b0;
      byp1_q <= 1'b0;
      byp2_q <= 1'b0;
      tag1_q <= '0;
      v1_q   <= 1'b0;
      a2_q   <= '0;
      b2_q   <= '0;
      low2_q <= 1'b0;
      tag2_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      low1_q <= low1_d;
      byp1_q <= byp1_d;
      byp2_q <= byp2_d;
      tag1_q <= tag1_d;
      v1_q   <= v1_d;
      a2_q   <= a2_d;
      b2_q   <= b2_d;
      low2_q <= low2_d;
      tag2_q <= tag2_d;
      v2_q   <= v2_d;
    end
  end

  if (STAGES <= 2) begin : g_lat2
    assign prod_last = prod_e2_c;
    assign low_last  = low2_q;
    assign tag_last  = tag2_q;
    assign v_last    = v2_q;
    assign busy_tail = 1'b0;
  end else begin : g_lat3
    logic [PW-1:0]    prod3_q, prod3_d;
    logic             low3_q, low3_d, v3_q, v3_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;

    always_comb begin
      prod3_d = prod3_q;
      low3_d  = low3_q;
      tag3_d  = tag3_q;
      if (!freeze && v2_q) begin
        prod3_d = prod_e2_c;
        low3_d  = low2_q;
        tag3_d  = tag2_q;
      end
      v3_d = flush ? 1'b0 : (freeze ? v3_q : v2_q);
    end

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        prod3_q <= '0;
        low3_q  <= 1'b0;
        tag3_q  <= '0;
        v3_q    <= 1'b0;
      end else begin
        prod3_q <= prod3_d;
        low3_q  <= low3_d;
        tag3_q  <= tag3_d;
        v3_q    <= v3_d;
      end
    end

    if (STAGES == 3) begin : g_last3
      assign prod_last = prod3_q;
      assign low_last  = low3_q;
      assign tag_last  = tag3_q;
      assign v_last    = v3_q;
      assign busy_tail = v3_q;
    end else begin : g_lat4
      logic [PW-1:0]    prod4_q, prod4_d;
      logic             low4_q, low4_d, v4_q, v4_d;
      logic [TAG_W-1:0] tag4_q, tag4_d;

      always_comb begin
        prod4_d = prod4_q;
        low4_d  = low4_q;
        tag4_d  = tag4_q;
        if (!freeze && v3_q) begin
          prod4_d = prod3_q;
          low4_d  = low3_q;
          tag4_d  = tag3_q;
        end
        v4_d = flush ? 1'b0 : (freeze ? v4_q : v3_q);
      end

      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          prod4_q <= '0;
          low4_q  <= 1'b0;
          tag4_q  <= '0;
          v4_q    <= 1'b0;
        end else begin
          prod4_q <= prod4_d;
          low4_q  <= low4_d;
          tag4_q  <= tag4_d;
          v4_q    <= v4_d;
        end
      end

      assign prod_last = prod4_q;
      assign low_last  = low4_q;
      assign tag_last  = tag4_q;
      assign v_last    = v4_q;
      assign busy_tail = v3_q | v4_q;
    end
  end

  // Zero when idle so the result can be OR-merged onto the shared bus
  always_comb begin
    out       = '0;
    out_tag   = '0;
    out_valid = v_last;
    busy      = v1_q | v2_q | busy_tail;
    if (v_last) begin
      out     = low_last ? prod_last[XLEN-1:0] : prod_last[PW-1:XLEN];
      out_tag = tag_last;
    end
  end

endmodule

// File: tb/tb_exu_mul_pipe_ctl.sv
// Directed bench for exu_mul_pipe_ctl: per-cycle vector table on a 32-bit/3-stage instance,
// plus latency sweep on 16-bit 2- and 4-stage instances and an asynchronous reset sequence.
module tb_exu_mul_pipe_ctl;

  typedef struct {
    logic        vin, s1, s2, low, byp1, byp2, frz, fl;
    logic [4:0]  tag;
    logic [31:0] a, b, lsu;
    logic        ev;
    logic [31:0] eo;
    logic [4:0]  et;
    logic        eb;
  } vec_t;

  localparam int NV = 38;

  logic        clk, rst_l, freeze, flush, valid_in, rs1_sign, rs2_sign, low, rs1_byp, rs2_byp;
  logic [4:0]  tag_in;
  logic [31:0] a, b, lsu;
  logic [15:0] a16, b16, lsu16;
  logic [31:0] out;
  logic        out_valid, busy;
  logic [4:0]  out_tag;
  logic [15:0] out2, out4;
  logic        ov2, ov4, busy2, busy4;
  logic [4:0]  ot2, ot4;

  int checks, errors;
  vec_t v [NV];

  exu_mul_pipe_ctl #(.XLEN(32), .STAGES(3), .TAG_W(5)) u_dut (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .rs1_byp(rs1_byp), .rs2_byp(rs2_byp),
    .tag_in(tag_in), .a(a), .b(b), .lsu_result_dc3(lsu),
    .out(out), .out_valid(out_valid), .out_tag(out_tag), .busy(busy));

  exu_mul_pipe_ctl #(.XLEN(16), .STAGES(2), .TAG_W(5)) u_s2 (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .rs1_byp(rs1_byp), .rs2_byp(rs2_byp),
    .tag_in(tag_in), .a(a16), .b(b16), .lsu_result_dc3(lsu16),
    .out(out2), .out_valid(ov2), .out_tag(ot2), .busy(busy2));

  exu_mul_pipe_ctl #(.XLEN(16), .STAGES(4), .TAG_W(5)) u_s4 (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .rs1_byp(rs1_byp), .rs2_byp(rs2_byp),
    .tag_in(tag_in), .a(a16), .b(b16), .lsu_result_dc3(lsu16),
    .out(out4), .out_valid(ov4), .out_tag(ot4), .busy(busy4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic s1, input logic s2, input logic lo,
                        input logic [4:0] tg, input logic [31:0] av, input logic [31:0] bv);
    v[i].vin = 1'b1; v[i].s1 = s1; v[i].s2 = s2; v[i].low = lo;
    v[i].tag = tg;   v[i].a = av;  v[i].b = bv;
  endtask

  task automatic set_exp(input int i, input logic [31:0] eo, input logic [4:0] et);
    v[i].ev = 1'b1; v[i].eo = eo; v[i].et = et;
  endtask

  task automatic drive_idle();
    valid_in = 0; rs1_sign = 0; rs2_sign = 0; low = 0; rs1_byp = 0; rs2_byp = 0;
    freeze = 0; flush = 0; tag_in = '0; a = '0; b = '0; lsu = '0; a16 = '0; b16 = '0; lsu16 = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NV; i++) begin
      v[i] = '{vin:0, s1:0, s2:0, low:0, byp1:0, byp2:0, frz:0, fl:0, tag:'0,
               a:'0, b:'0, lsu:'0, ev:0, eo:'0, et:'0, eb:0};
    end
    // signed low product
    set_op(0, 1, 1, 1, 5'd9, 32'd7, 32'hFFFF_FFFD);
    set_exp(3, 32'hFFFF_FFEB, 5'd9);
    // high-half modes back to back
    set_op(6, 0, 0, 0, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_op(7, 1, 1, 0, 5'd2, 32'h8000_0000, 32'h8000_0000);
    set_op(8, 1, 0, 0, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_exp(9,  32'hFFFF_FFFE, 5'd1);
    set_exp(10, 32'h4000_0000, 5'd2);
    set_exp(11, 32'hFFFF_FFFF, 5'd3);
    // load bypass: lsu value taken while the op sits in E1
    set_op(13, 0, 0, 1, 5'd4, 32'd0, 32'd6);
    v[13].byp1 = 1; v[13].lsu = 32'h77; v[14].lsu = 32'd5; v[15].lsu = 32'h77;
    set_exp(16, 32'd30, 5'd4);
    // freeze in the middle of the pipe
    set_op(18, 1, 1, 1, 5'd9, 32'd7, 32'hFFFF_FFFD);
    v[20].frz = 1; v[21].frz = 1;
    set_exp(23, 32'hFFFF_FFEB, 5'd9);
    // freeze with a result in the last stage
    set_op(25, 0, 0, 1, 5'd10, 32'd3, 32'd5);
    v[28].frz = 1; v[29].frz = 1;
    set_exp(28, 32'd15, 5'd10);
    set_exp(29, 32'd15, 5'd10);
    set_exp(30, 32'd15, 5'd10);
    // flush with freeze kills everything including the same-cycle issue
    set_op(32, 0, 0, 1, 5'd11, 32'd2, 32'd2);
    set_op(33, 0, 0, 1, 5'd12, 32'd3, 32'd3);
    set_op(34, 0, 0, 1, 5'd13, 32'd9, 32'd9);
    v[34].frz = 1; v[34].fl = 1;
    for (int i = 1; i <= 3; i++)   v[i].eb = 1;
    for (int i = 7; i <= 11; i++)  v[i].eb = 1;
    for (int i = 14; i <= 16; i++) v[i].eb = 1;
    for (int i = 19; i <= 23; i++) v[i].eb = 1;
    for (int i = 26; i <= 30; i++) v[i].eb = 1;
    v[33].eb = 1; v[34].eb = 1;

    rst_l = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("reset out",       64'(out),       64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_tag",   64'(out_tag),   64'd0);
    chk("reset busy",      64'(busy),      64'd0);
    rst_l = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      valid_in = v[i].vin; rs1_sign = v[i].s1; rs2_sign = v[i].s2; low = v[i].low;
      rs1_byp = v[i].byp1; rs2_byp = v[i].byp2; freeze = v[i].frz; flush = v[i].fl;
      tag_in = v[i].tag; a = v[i].a; b = v[i].b; lsu = v[i].lsu;
      #1;
      chk($sformatf("c%0d out", i),       64'(out),       64'(v[i].eo));
      chk($sformatf("c%0d out_valid", i), 64'(out_valid), 64'(v[i].ev));
      chk($sformatf("c%0d out_tag", i),   64'(out_tag),   64'(v[i].et));
      chk($sformatf("c%0d busy", i),      64'(busy),      64'(v[i].eb));
    end

    // 16-bit MULH 0x8000*0x8000 at latency 2 and 4
    @(negedge clk);
    drive_idle();
    valid_in = 1; rs1_sign = 1; rs2_sign = 1; low = 0; tag_in = 5'd6;
    a16 = 16'h8000; b16 = 16'h8000;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
        drive_idle();
      end
      #1;
      chk($sformatf("s2 k%0d valid", k), 64'(ov2),  64'(k == 2));
      chk($sformatf("s2 k%0d out", k),   64'(out2), (k == 2) ? 64'h4000 : 64'd0);
      chk($sformatf("s2 k%0d tag", k),   64'(ot2),  (k == 2) ? 64'd6 : 64'd0);
      chk($sformatf("s4 k%0d valid", k), 64'(ov4),  64'(k == 4));
      chk($sformatf("s4 k%0d out", k),   64'(out4), (k == 4) ? 64'h4000 : 64'd0);
      chk($sformatf("s4 k%0d tag", k),   64'(ot4),  (k == 4) ? 64'd6 : 64'd0);
    end

    // asynchronous reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_idle();
      valid_in = 1; rs1_sign = 1; rs2_sign = 1; low = 1; tag_in = 5'(9 + k);
      a = 32'd7; b = 32'hFFFF_FFFD;
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    chk("pre-reset out",       64'(out),       64'hFFFF_FFEB);
    #1 rst_l = 1'b0;
    #1;
    chk("async reset out",       64'(out),       64'd0);
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset out_tag",   64'(out_tag),   64'd0);
    chk("async reset busy",      64'(busy),      64'd0);
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-reset k%0d out_valid", k), 64'(out_valid), 64'd0);
      chk($sformatf("post-reset k%0d busy", k),      64'(busy),      64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
